klingon_seg_decoder: RTL and testbench

- Receive side of the Klingon 7-segment glyph path: accepts a raw 7-bit segment pattern, filters glitches, decodes it back to a 4-bit digit 0-9 and hands it downstream over a valid/ready handshake.
- Sits between a segment-pattern source (sensor, loopback or test bus) and digit-consuming logic.
- Each held glyph is emitted exactly once. Unknown patterns are flagged rather than dropped.

---
 rtl/klingon_pkg.sv | 32 +++
 rtl/klingon_seg_decoder_if.sv | 39 +++
 rtl/klingon_glyph_lut.sv | 41 ++++
 rtl/klingon_seg_decoder.sv | 149 ++++++++++++++
 tb/tb_klingon_seg_decoder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/klingon_pkg.sv
// ---------------------------------------------------------------------------
// klingon_pkg
// Shared definitions for the Klingon 7-segment glyph path. The glyph table is
// used by both the encoder and the decoder so the two directions cannot drift.
//   GLYPH_0..GLYPH_9 : segment patterns for digits 0-9 (bit 6 = MSB)
//   GLYPH_BLANK      : separator pattern, never emitted as a digit
//   DIGIT_ERR        : digit value reported for an unknown pattern
//   state_t          : decoder FSM states
// ---------------------------------------------------------------------------
package klingon_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000001;
    localparam logic [6:0] GLYPH_2     = 7'b1000001;
    localparam logic [6:0] GLYPH_3     = 7'b1001001;
    localparam logic [6:0] GLYPH_4     = 7'b1100010;
    localparam logic [6:0] GLYPH_5     = 7'b1011100;
    localparam logic [6:0] GLYPH_6     = 7'b1010010;
    localparam logic [6:0] GLYPH_7     = 7'b1100100;
    localparam logic [6:0] GLYPH_8     = 7'b0110110;
    localparam logic [6:0] GLYPH_9     = 7'b1110110;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    localparam logic [3:0] DIGIT_ERR   = 4'hF;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } state_t;

endpackage

// File: rtl/klingon_seg_decoder_if.sv
// ---------------------------------------------------------------------------
// klingon_seg_decoder_if
// Bundle between a segment-pattern source / digit consumer (master) and the
// decoder (slave).
//   seg_in    : raw 7-bit segment pattern
//   out_digit : decoded digit, DIGIT_ERR when out_err = 1
//   out_err   : pattern was non-blank and not in the glyph table
//   out_valid : output register holds an unconsumed glyph
//   out_ready : consumer accepts the glyph
//   ovf       : sticky, a glyph was lost because the output register was full
//   ovf_clr   : synchronous clear of ovf
//   dbg_state : current decoder FSM state
// Handshake: a transfer happens on a rising edge where out_valid && out_ready;
// while out_valid && !out_ready, out_digit/out_err hold their value, and
// out_valid never drops without a transfer (reset excepted).
// ---------------------------------------------------------------------------
interface klingon_seg_decoder_if;
    import klingon_pkg::*;

    logic [6:0] seg_in;
    logic [3:0] out_digit;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       ovf;
    logic       ovf_clr;
    state_t     dbg_state;

    modport master (
        output seg_in, out_ready, ovf_clr,
        input  out_digit, out_err, out_valid, ovf, dbg_state
    );

    modport slave (
        input  seg_in, out_ready, ovf_clr,
        output out_digit, out_err, out_valid, ovf, dbg_state
    );

endinterface

// File: rtl/klingon_glyph_lut.sv
// ---------------------------------------------------------------------------
// klingon_glyph_lut
// Purely combinational lookup of a 7-bit segment pattern.
//   seg      : segment pattern
//   is_blank : pattern is the separator
//   is_err   : pattern is non-blank and not a known glyph
//   digit    : decoded digit (DIGIT_ERR for unknown, 0 for blank)
// ---------------------------------------------------------------------------
module klingon_glyph_lut
    import klingon_pkg::*;
(
    input  logic [6:0] seg,
    output logic       is_blank,
    output logic       is_err,
    output logic [3:0] digit
);

    always_comb begin
        is_blank = 1'b0;
        is_err   = 1'b0;
        digit    = 4'd0;
        case (seg)
            GLYPH_0:     digit = 4'd0;
            GLYPH_1:     digit = 4'd1;
            GLYPH_2:     digit = 4'd2;
            GLYPH_3:     digit = 4'd3;
            GLYPH_4:     digit = 4'd4;
            GLYPH_5:     digit = 4'd5;
            GLYPH_6:     digit = 4'd6;
            GLYPH_7:     digit = 4'd7;
            GLYPH_8:     digit = 4'd8;
            GLYPH_9:     digit = 4'd9;
            GLYPH_BLANK: is_blank = 1'b1;
            default: begin
                is_err = 1'b1;
                digit  = DIGIT_ERR;
            end
        endcase
    end

endmodule

// File: rtl/klingon_seg_decoder.sv
// ---------------------------------------------------------------------------
// klingon_seg_decoder
// Receive side of the glyph path: registers seg_in, requires STABLE_CYCLES
// identical non-blank samples, decodes the pattern and emits it once over a
// valid/ready handshake. Unknown patterns are emitted with out_err set.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : klingon_seg_decoder_if slave (pattern in, digit out, ovf)
// Parameters: STABLE_CYCLES (1..255), CNT_W with 2**CNT_W > STABLE_CYCLES.
// ---------------------------------------------------------------------------
module klingon_seg_decoder
    import klingon_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    klingon_seg_decoder_if.slave  bus
);

    // Counter value that, once incremented, reaches STABLE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [6:0]       sample_q;
    logic [6:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             emit;

    logic [3:0]       out_digit_q;
    logic             out_err_q;
    logic             out_valid_q;
    logic             ovf_q;

    logic             lut_blank;
    logic             lut_err;
    logic [3:0]       lut_digit;
    logic             accept;

    klingon_glyph_lut u_lut (
        .seg      (sample_q),
        .is_blank (lut_blank),
        .is_err   (lut_err),
        .digit    (lut_digit)
    );

    // Next-state: emit fires on the same edge the counter reaches
    // STABLE_CYCLES, giving STABLE_CYCLES + 1 cycles of total latency.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        case (state_q)
            BLANK: begin
                cnt_d = '0;
                if (!lut_blank) begin
                    last_d = sample_q;
                    cnt_d  = CNT_ONE;
                    if (STABLE_CYCLES == 1) begin
                        emit    = 1'b1;
                        state_d = HELD;
                    end else begin
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                if (lut_blank) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                end else if (sample_q == last_q) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        emit    = 1'b1;
                        state_d = HELD;
                    end
                end else begin
                    last_d = sample_q;
                    cnt_d  = CNT_ONE;
                end
            end
            HELD: begin
                // Counter stays saturated at STABLE_CYCLES while held.
                if (lut_blank) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                end else if (sample_q != last_q) begin
                    last_d  = sample_q;
                    cnt_d   = CNT_ONE;
                    state_d = COUNT;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BLANK;
            sample_q <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= bus.seg_in;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign accept = out_valid_q && bus.out_ready;

    // A new glyph may replace one being consumed in the same cycle; otherwise
    // a full register drops the new glyph and flags ovf (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_digit_q <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (emit && (!out_valid_q || accept)) begin
                out_digit_q <= lut_digit;
                out_err_q   <= lut_err;
                out_valid_q <= 1'b1;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end

            if (emit && out_valid_q && !accept) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.out_digit = out_digit_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_klingon_seg_decoder.sv
// ---------------------------------------------------------------------------
// tb_klingon_seg_decoder
// Directed and randomized stimulus for klingon_seg_decoder. A run-length
// reference model (how many consecutive identical non-blank samples have been
// seen) predicts every output on every cycle; directed phases additionally
// check the digits handed downstream against fixed expectations.
// ---------------------------------------------------------------------------
module tb_klingon_seg_decoder;
    import klingon_pkg::*;

    localparam int STABLE = 4;

    logic clk;
    logic rst_n;

    klingon_seg_decoder_if bus ();

    klingon_seg_decoder #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model state ----------------
    logic [6:0] tbl [10] = '{7'b0111111, 7'b0000001, 7'b1000001, 7'b1001001,
                             7'b1100010, 7'b1011100, 7'b1010010, 7'b1100100,
                             7'b0110110, 7'b1110110};
    logic [6:0] m_sample;   // pattern the decoder is looking at this cycle
    logic [6:0] m_prev;     // previous pattern looked at
    int         m_run;      // consecutive identical non-blank samples
    logic       e_valid;
    logic [3:0] e_digit;
    logic       e_err;
    logic       e_ovf;

    // DUT digits handed downstream: {err, digit}
    logic [4:0] obs_q [$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] d, output logic e);
        d = 4'hF;
        e = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (p == tbl[i]) begin
                d = 4'(i);
                e = 1'b0;
            end
        end
    endfunction

    task automatic model_reset();
        m_sample = '0;
        m_prev   = '0;
        m_run    = 0;
        e_valid  = 1'b0;
        e_digit  = '0;
        e_err    = 1'b0;
        e_ovf    = 1'b0;
    endtask

    // Applied at each rising edge with the inputs that edge sees.
    task automatic model_edge();
        logic       emit;
        logic       acc;
        logic [3:0] d;
        logic       e;
        if (!rst_n) return;
        if (m_sample == 7'd0)            m_run = 0;
        else if (m_sample == m_prev)     m_run = (m_run <= STABLE) ? m_run + 1 : m_run;
        else                             m_run = 1;
        m_prev = m_sample;
        emit = (m_run == STABLE);
        acc  = e_valid && bus.out_ready;
        ref_decode(m_sample, d, e);
        if (emit && e_valid && !acc) e_ovf = 1'b1;
        else if (bus.ovf_clr)        e_ovf = 1'b0;
        if (emit && (!e_valid || acc)) begin
            e_valid = 1'b1;
            e_digit = d;
            e_err   = e;
        end else if (acc) begin
            e_valid = 1'b0;
        end
        m_sample = bus.seg_in;
    endtask

    task automatic check_outputs();
        chk("out_valid", 8'(bus.out_valid), 8'(e_valid));
        chk("out_digit", 8'(bus.out_digit), 8'(e_digit));
        chk("out_err",   8'(bus.out_err),   8'(e_err));
        chk("ovf",       8'(bus.ovf),       8'(e_ovf));
    endtask

    // One clock: update model at the edge, check on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic [6:0] seg, input logic rdy, input logic clr, input int n);
        for (int k = 0; k < n; k++) begin
            bus.seg_in    = seg;
            bus.out_ready = rdy;
            bus.ovf_clr   = clr;
            if (bus.out_valid && rdy) obs_q.push_back({bus.out_err, bus.out_digit});
            tick();
        end
    endtask

    // Holds seg with ready high and returns cycles until out_valid rises.
    task automatic latency(input logic [6:0] seg, output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            bus.seg_in    = seg;
            bus.out_ready = 1'b1;
            bus.ovf_clr   = 1'b0;
            if (bus.out_valid) obs_q.push_back({bus.out_err, bus.out_digit});
            tick();
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic chk_obs(input string tag, input logic [4:0] exp [$]);
        chk({tag, "_count"}, 8'(obs_q.size()), 8'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs_q.size(); i++)
            chk({tag, "_glyph"}, 8'(obs_q[i]), 8'(exp[i]));
        obs_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         lat;
        logic [6:0] pool [13];
        logic [6:0] seg;
        logic [4:0] exp_q [$];

        bus.seg_in    = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        rst_n         = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", 8'(bus.dbg_state), 8'(BLANK));
        check_outputs();
        rst_n = 1'b1;

        // Basic decode: digit 7 appears after STABLE + 1 cycles, exactly once.
        obs_q.delete();
        latency(7'b1100100, lat);
        chk("latency", 8'(lat), 8'(STABLE + 1));
        cyc(7'b1100100, 1'b1, 1'b0, 10 - lat);
        cyc(7'b0000000, 1'b1, 1'b0, 2);
        exp_q = '{5'h07};
        chk_obs("basic", exp_q);

        // Glitch filter: short 8 ignored, 9 emitted once.
        cyc(7'b0110110, 1'b1, 1'b0, 3);
        cyc(7'b1110110, 1'b1, 1'b0, 6);
        cyc(7'b0000000, 1'b1, 1'b0, 2);
        exp_q = '{5'h09};
        chk_obs("glitch", exp_q);

        // Separator allows repeat; no separator means one emit.
        cyc(7'b0000001, 1'b1, 1'b0, 6);
        cyc(7'b0000000, 1'b1, 1'b0, 2);
        cyc(7'b0000001, 1'b1, 1'b0, 6);
        cyc(7'b0000000, 1'b1, 1'b0, 2);
        exp_q = '{5'h01, 5'h01};
        chk_obs("repeat", exp_q);
        cyc(7'b0000001, 1'b1, 1'b0, 12);
        cyc(7'b0000000, 1'b1, 1'b0, 2);
        exp_q = '{5'h01};
        chk_obs("held", exp_q);

        // Unknown pattern is flagged, not dropped.
        cyc(7'b1111111, 1'b1, 1'b0, 6);
        cyc(7'b0000000, 1'b1, 1'b0, 2);
        exp_q = '{5'h1F};
        chk_obs("error_glyph", exp_q);

        // Backpressure: 3 held, 5 lost, ovf set.
        cyc(7'b1001001, 1'b0, 1'b0, 6);
        cyc(7'b0000000, 1'b0, 1'b0, 2);
        cyc(7'b1011100, 1'b0, 1'b0, 6);
        cyc(7'b0000000, 1'b0, 1'b0, 2);
        chk("bp_digit", 8'(bus.out_digit), 8'd3);
        chk("bp_ovf",   8'(bus.ovf),       8'd1);
        cyc(7'b0000000, 1'b1, 1'b0, 3);
        exp_q = '{5'h03};
        chk_obs("bp_drain", exp_q);
        cyc(7'b0000000, 1'b1, 1'b1, 1);
        chk("ovf_clr", 8'(bus.ovf), 8'd0);

        // ovf_clr coinciding with a new overflow leaves ovf set.
        cyc(7'b1001001, 1'b0, 1'b0, 6);
        cyc(7'b0000000, 1'b0, 1'b0, 2);
        cyc(7'b1011100, 1'b0, 1'b0, STABLE);
        cyc(7'b1011100, 1'b0, 1'b1, 1);
        cyc(7'b1011100, 1'b0, 1'b0, 1);
        chk("ovf_set_wins", 8'(bus.ovf), 8'd1);
        cyc(7'b0000000, 1'b1, 1'b0, 3);
        obs_q.delete();

        // Reset mid-count with a pending glyph and ovf set.
        cyc(7'b1100100, 1'b0, 1'b0, 6);
        cyc(7'b0000000, 1'b0, 1'b0, 2);
        cyc(7'b1001001, 1'b0, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 8'(bus.out_valid), 8'd0);
        chk("rst_digit", 8'(bus.out_digit), 8'd0);
        chk("rst_ovf",   8'(bus.ovf),       8'd0);
        chk("rst_state", 8'(bus.dbg_state), 8'(BLANK));
        cyc(7'b1001001, 1'b0, 1'b0, 2);
        rst_n = 1'b1;
        obs_q.delete();
        latency(7'b1001001, lat);
        chk("rst_latency", 8'(lat), 8'(STABLE + 1));
        cyc(7'b0000000, 1'b1, 1'b0, 3);
        obs_q.delete();

        // Randomized glyph stream with random backpressure and clears.
        for (int i = 0; i < 10; i++) pool[i] = tbl[i];
        pool[10] = 7'b0000000;
        pool[11] = 7'b1111111;
        pool[12] = 7'b0101010;
        for (int i = 0; i < 120; i++) begin
            seg = pool[$urandom_range(0, 12)];
            cyc(seg, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                int'($urandom_range(1, 8)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
